// File: rtl/serial_adder_ctrl_if.sv
// ----------------------------------------------------------------------------
// serial_adder_ctrl_if : start/result handshake bundle for serial_adder_ctrl
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             busy;

  modport master (
    output start_valid, A, B, Cin, res_ready,
    input  start_ready, res_valid, Sum, Cout, busy
  );

  modport slave (
    input  start_valid, A, B, Cin, res_ready,
    output start_ready, res_valid, Sum, Cout, busy
  );
endinterface

`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
// ----------------------------------------------------------------------------
// serial_adder_ctrl : bit-serial WIDTH-bit adder, one full_adder reused per bit
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module full_adder (
  input  wire logic a,
  input  wire logic b,
  input  wire logic cin,
  output logic      sum,
  output logic      cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  serial_adder_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_s_sr;
  logic [WIDTH-1:0] w_s_next;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             w_fa_sum;
  logic             w_fa_cout;
  logic             w_accept;
  logic             w_last;
  logic             w_start_ready;
  logic             w_busy;
  logic             w_res_valid;

  full_adder u_fa (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .cin  (r_carry),
    .sum  (w_fa_sum),
    .cout (w_fa_cout)
  );

  assign w_accept = bus.start_valid && (r_state == S_IDLE);
  assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_RUN;
      S_RUN:   if (w_last) w_next_state = S_DONE;
      S_DONE:  if (bus.res_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_start_ready = (r_state == S_IDLE);
    w_busy        = (r_state != S_IDLE);
    w_res_valid   = (r_state == S_DONE);
  end

  // Sum bit enters at the MSB; after WIDTH shifts bit 0 of the operation lands in bit 0.
  always_comb begin
    w_s_next            = r_s_sr >> 1;
    w_s_next[WIDTH-1]   = w_fa_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_s_sr  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a_sr  <= bus.A;
      r_b_sr  <= bus.B;
      r_carry <= bus.Cin;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a_sr  <= r_a_sr >> 1;
      r_b_sr  <= r_b_sr >> 1;
      r_s_sr  <= w_s_next;
      r_carry <= w_fa_cout;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_sum  <= w_s_next;
        r_cout <= w_fa_cout;
      end
    end
  end

  assign bus.start_ready = w_start_ready;
  assign bus.busy        = w_busy;
  assign bus.res_valid   = w_res_valid;
  assign bus.Sum         = r_sum;
  assign bus.Cout        = r_cout;
endmodule

`default_nettype wire
